// File: rtl/pslip_iter_scheduler.sv
// Priority-iSLIP crossbar scheduler: K request-grant-accept iterations, one per clk, then a one-cycle decision_valid pulse.
// Optional PSLIP_EARLY_EXIT_EN: leave ITER after any iteration that adds no new matches.
module pslip_iter_scheduler #(
  parameter int N        = 4,
  parameter int P        = 16,
  parameter int MAX_ITER = 4,
  localparam int C       = $clog2(P),
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IW-1:0]     num_iter,
  input  logic [N*N*C-1:0]  pri_req_in,
  output logic              busy,
  output logic [N*N-1:0]    decision,
  output logic              decision_valid,
  output logic [IW-1:0]     iter_used
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t              state, state_nxt;
  logic [N*N*C-1:0]    req_reg;
  logic [IW-1:0]       k_reg;
  logic [IW-1:0]       k_clamp;
  logic [IW-1:0]       iter_cnt;
  logic [PW-1:0]       gnt_ptr [N];
  logic [PW-1:0]       acc_ptr [N];
  logic [N-1:0]        row_m;
  logic [N-1:0]        col_m;
  logic [N*N-1:0]      gnt;   // bit i*N+j: output j grants input i
  logic [N*N-1:0]      acc;   // bit i*N+j: input i accepts output j
  logic                last_iter;
  logic                leave_iter;

  always_comb begin
    k_clamp = num_iter;
    if (num_iter == '0)
      k_clamp = IW'(1);
    else if (num_iter > IW'(MAX_ITER))
      k_clamp = IW'(MAX_ITER);
  end

  always_comb begin
    row_m = '0;
    col_m = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (decision[i*N+j]) begin
          row_m[i] = 1'b1;
          col_m[j] = 1'b1;
        end
      end
    end
  end

  // Scanning in round-robin order with a strict '>' keeps the first tied entry after the pointer.
  always_comb begin : grant_stage
    logic [C-1:0] best_p;
    int           best_i;
    int           idx;
    gnt    = '0;
    best_p = '0;
    best_i = 0;
    idx    = 0;
    for (int j = 0; j < N; j++) begin
      best_p = '0;
      best_i = 0;
      if (!col_m[j]) begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(gnt_ptr[j]) + k) % N;
          if (!row_m[idx] && (req_reg[(idx*N+j)*C +: C] > best_p)) begin
            best_p = req_reg[(idx*N+j)*C +: C];
            best_i = idx;
          end
        end
        if (best_p != '0)
          gnt[best_i*N+j] = 1'b1;
      end
    end
  end

  always_comb begin : accept_stage
    logic [C-1:0] best_p;
    logic         found;
    int           best_j;
    int           idx;
    acc    = '0;
    best_p = '0;
    found  = 1'b0;
    best_j = 0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      best_p = '0;
      found  = 1'b0;
      best_j = 0;
      if (!row_m[i]) begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(acc_ptr[i]) + k) % N;
          if (gnt[i*N+idx] && (!found || (req_reg[(i*N+idx)*C +: C] > best_p))) begin
            best_p = req_reg[(i*N+idx)*C +: C];
            best_j = idx;
            found  = 1'b1;
          end
        end
        if (found)
          acc[i*N+best_j] = 1'b1;
      end
    end
  end

  assign last_iter = (iter_cnt >= k_reg);
`ifdef PSLIP_EARLY_EXIT_EN
  assign leave_iter = last_iter || (acc == '0);
`else
  assign leave_iter = last_iter;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (leave_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_reg   <= '0;
      k_reg     <= '0;
      iter_cnt  <= '0;
      decision  <= '0;
      iter_used <= '0;
      for (int n = 0; n < N; n++) begin
        gnt_ptr[n] <= '0;
        acc_ptr[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_reg  <= pri_req_in;
            k_reg    <= k_clamp;
            decision <= '0;
            iter_cnt <= IW'(1);
          end
        end
        ITER: begin
          decision <= decision | acc;
          // Only first-iteration accepts move pointers, which is what keeps iSLIP starvation-free.
          if (iter_cnt == IW'(1)) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                if (acc[i*N+j]) begin
                  gnt_ptr[j] <= PW'((i + 1) % N);
                  acc_ptr[i] <= PW'((j + 1) % N);
                end
              end
            end
          end
          if (leave_iter)
            iter_used <= iter_cnt;
          else
            iter_cnt <= iter_cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign decision_valid = (state == DONE);

endmodule

// File: tb/tb_pslip_iter_scheduler.sv
// Directed bench for pslip_iter_scheduler (N=4, P=16, MAX_ITER=4); expectations are hand-computed per scenario.
module tb_pslip_iter_scheduler;

  localparam int N  = 4;
  localparam int C  = 4;
  localparam int IW = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [IW-1:0]    num_iter;
  logic [N*N*C-1:0] pri_req_in;
  logic             busy;
  logic [N*N-1:0]   decision;
  logic             decision_valid;
  logic [IW-1:0]    iter_used;

  int n_cmp = 0;
  int n_err = 0;

  pslip_iter_scheduler #(.N(4), .P(16), .MAX_ITER(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_iter       (num_iter),
    .pri_req_in     (pri_req_in),
    .busy           (busy),
    .decision       (decision),
    .decision_valid (decision_valid),
    .iter_used      (iter_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*N*C-1:0] put(input logic [N*N*C-1:0] base, input int i, input int j,
                                           input logic [C-1:0] p);
    logic [N*N*C-1:0] r;
    r = base;
    r[(i*N+j)*C +: C] = p;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Cycle 0 ends at the edge that samples start; cyc is the cycle in which decision_valid is seen.
  task automatic run_sched(input logic [N*N*C-1:0] req, input logic [IW-1:0] k, output int cyc);
    @(negedge clk);
    pri_req_in = req;
    num_iter   = k;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!decision_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!decision_valid) begin
      n_err++;
      $display("FAIL wait_valid: no decision_valid within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    logic [N*N*C-1:0] tie;
    int cyc;
    int pulses;
    reset = 1'b0;
    start = 1'b0;
    num_iter = '0;
    pri_req_in = '0;
    #3;
    n_cmp++; if (decision !== 16'h0) begin n_err++; $display("FAIL rst_decision: got %h want 0", decision); end
    n_cmp++; if (decision_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", decision_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (iter_used !== 3'd0) begin n_err++; $display("FAIL rst_iter_used: got %0d want 0", iter_used); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tie = put(put('0, 0, 0, 4'd4), 1, 0, 4'd4);
    run_sched(tie, 3'd1, cyc);  // moves gnt_ptr[0] to 1
    @(negedge clk);
    pri_req_in = tie;
    num_iter   = 3'd4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (decision !== 16'h0) begin n_err++; $display("FAIL midrst_decision: got %h want 0", decision); end
    n_cmp++; if (iter_used !== 3'd0) begin n_err++; $display("FAIL midrst_iter_used: got %0d want 0", iter_used); end
    pulses = 0;
    repeat (2) begin @(negedge clk); if (decision_valid) pulses++; end
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (decision_valid) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_valid: got %0d pulses want 0", pulses); end
    run_sched(tie, 3'd1, cyc);
    n_cmp++; if (decision !== 16'h0001) begin n_err++; $display("FAIL midrst_ptr0: got %h want 0001", decision); end
  endtask

  task automatic test_single();
    int cyc;
    do_reset();
    run_sched(put('0, 1, 2, 4'd5), 3'd1, cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", cyc); end
    n_cmp++; if (decision !== 16'h0040) begin n_err++; $display("FAIL single_decision: got %h want 0040", decision); end
    n_cmp++; if (iter_used !== 3'd1) begin n_err++; $display("FAIL single_iter_used: got %0d want 1", iter_used); end
    @(negedge clk);
    n_cmp++; if (decision_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b want 0", decision_valid); end
  endtask

  task automatic test_priority();
    int cyc;
    do_reset();
    run_sched(put(put('0, 0, 0, 4'd3), 1, 0, 4'd9), 3'd1, cyc);
    n_cmp++; if (decision !== 16'h0010) begin n_err++; $display("FAIL prio_high: got %h want 0010", decision); end
    do_reset();
    run_sched(put('0, 0, 0, 4'd3), 3'd1, cyc);
    n_cmp++; if (decision !== 16'h0001) begin n_err++; $display("FAIL prio_low_only: got %h want 0001", decision); end
  endtask

  task automatic test_back_to_back();
    logic [N*N*C-1:0] tie;
    logic [N*N-1:0]   want [3];
    int cyc;
    want[0] = 16'h0001;
    want[1] = 16'h0010;
    want[2] = 16'h0001;
    tie = put(put('0, 0, 0, 4'd4), 1, 0, 4'd4);
    do_reset();
    for (int s = 0; s < 3; s++) begin
      run_sched(tie, 3'd1, cyc);
      n_cmp++;
      if (decision !== want[s]) begin
        n_err++;
        $display("FAIL rotate_%0d: got %h want %h", s, decision, want[s]);
      end
    end
  endtask

  task automatic test_multi_iter();
    logic [N*N*C-1:0] req;
    int cyc;
    req = put(put(put('0, 0, 0, 4'd5), 0, 1, 4'd5), 1, 1, 4'd5);
    do_reset();
    run_sched(req, 3'd1, cyc);
    n_cmp++; if (decision !== 16'h0001) begin n_err++; $display("FAIL multi_k1: got %h want 0001", decision); end
    do_reset();
    run_sched(req, 3'd2, cyc);
    n_cmp++; if (decision !== 16'h0021) begin n_err++; $display("FAIL multi_k2_dec: got %h want 0021", decision); end
    n_cmp++; if (iter_used !== 3'd2) begin n_err++; $display("FAIL multi_k2_used: got %0d want 2", iter_used); end
    do_reset();
    run_sched(req, 3'd4, cyc);
    n_cmp++; if (decision !== 16'h0021) begin n_err++; $display("FAIL multi_k4_dec: got %h want 0021", decision); end
`ifdef PSLIP_EARLY_EXIT_EN
    n_cmp++; if (iter_used !== 3'd3) begin n_err++; $display("FAIL multi_k4_used: got %0d want 3", iter_used); end
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL multi_k4_latency: got %0d want 4", cyc); end
`else
    n_cmp++; if (iter_used !== 3'd4) begin n_err++; $display("FAIL multi_k4_used: got %0d want 4", iter_used); end
    n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL multi_k4_latency: got %0d want 5", cyc); end
`endif
  endtask

  task automatic test_clamp_busy();
    logic [N*N*C-1:0] req;
    int cyc;
    int pulses;
    req = put('0, 1, 2, 4'd5);
    do_reset();
    run_sched(req, 3'd0, cyc);
    n_cmp++; if (iter_used !== 3'd1) begin n_err++; $display("FAIL clamp0_used: got %0d want 1", iter_used); end
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL clamp0_latency: got %0d want 2", cyc); end
    run_sched(req, 3'd7, cyc);
`ifdef PSLIP_EARLY_EXIT_EN
    n_cmp++; if (iter_used !== 3'd2) begin n_err++; $display("FAIL clamp7_used: got %0d want 2", iter_used); end
`else
    n_cmp++; if (iter_used !== 3'd4) begin n_err++; $display("FAIL clamp7_used: got %0d want 4", iter_used); end
    n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL clamp7_latency: got %0d want 5", cyc); end
`endif
    // start re-pulsed and requests changed while busy must not disturb the running schedule
    do_reset();
    @(negedge clk);
    pri_req_in = req;
    num_iter   = 3'd4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_iter: got %b want 1", busy); end
    pulses = 0;
    start = 1'b1;
    pri_req_in = put('0, 3, 3, 4'd15);
    @(negedge clk);
    if (decision_valid) pulses++;
    start = 1'b0;
    repeat (12) begin @(negedge clk); if (decision_valid) pulses++; end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL busy_single_pulse: got %0d want 1", pulses); end
    n_cmp++; if (decision !== 16'h0040) begin n_err++; $display("FAIL busy_hold_dec: got %h want 0040", decision); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_empty();
    int cyc;
    do_reset();
    run_sched('0, 3'd2, cyc);
    n_cmp++; if (decision !== 16'h0) begin n_err++; $display("FAIL empty_dec: got %h want 0", decision); end
`ifdef PSLIP_EARLY_EXIT_EN
    n_cmp++; if (iter_used !== 3'd1) begin n_err++; $display("FAIL empty_used: got %0d want 1", iter_used); end
`else
    n_cmp++; if (iter_used !== 3'd2) begin n_err++; $display("FAIL empty_used: got %0d want 2", iter_used); end
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL empty_latency: got %0d want 3", cyc); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_multi_iter();
    test_clamp_busy();
    test_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
